// File: rtl/crc_checker.sv
// ---------------------------------------------------------------------------
// crc_checker
//
// Serial CRC checker. Payload bits arrive on DATA while ACTIVE is high and
// are folded into a DATA_WIDTH-bit CRC register. The received CRC then
// arrives LSB first on CRC_IN while CRC_VALID is high. Each received bit is
// compared against the low bit of the register, and the register is shifted
// right so that the next CRC bit lines up with r[0]. After the last CRC bit
// the frame result is published with a one-cycle DONE pulse.
//
// Parameters
//   DATA_WIDTH : width of the CRC register and of the CRC field
//   SEED       : CRC register value at reset and at the start of each frame
//
// Ports
//   CLK       in   1   clock, rising edge
//   RST       in   1   asynchronous active-low reset
//   DATA      in   1   serial payload bit, sampled while ACTIVE=1
//   ACTIVE    in   1   payload qualifier (has priority over CRC_VALID)
//   CRC_IN    in   1   serial received CRC bit, LSB first
//   CRC_VALID in   1   CRC bit qualifier
//   DONE      out  1   one-cycle pulse, frame result valid
//   ERR       out  1   1 = CRC mismatch or aborted frame, held until next DONE
//   LEN       out  16  payload bit count of last frame, held until next DONE
//   ERR_CNT   out  8   saturating count of frames reported with ERR=1
// ---------------------------------------------------------------------------
module crc_checker #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(8'hD8)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DATA,
  input  logic        ACTIVE,
  input  logic        CRC_IN,
  input  logic        CRC_VALID,
  output logic        DONE,
  output logic        ERR,
  output logic [15:0] LEN,
  output logic [7:0]  ERR_CNT
);

  // Index counter must be able to hold DATA_WIDTH-1 (the last index checked
  // before completion).
  localparam int IDX_W = (DATA_WIDTH < 2) ? 1 : $clog2(DATA_WIDTH + 1);

  // The register update is a right shift with the feedback bit XORed into
  // the top bit, the bit below it, and bit 2. For the 8-bit case that is
  // r <= (r >> 1) ^ (fb ? 8'hC4 : 0).
  localparam logic [DATA_WIDTH-1:0] FB_MASK =
    DATA_WIDTH'((1 << (DATA_WIDTH - 1)) | (1 << (DATA_WIDTH - 2)) | (1 << 2));

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RX_DATA = 2'd1,
    RX_CRC  = 2'd2
  } state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   crc_q;
  logic [15:0]             bitCnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    sticky_q;
  logic                    done_q;
  logic                    err_q;
  logic [15:0]             len_q;
  logic [7:0]              errCnt_q;

  logic [DATA_WIDTH-1:0]   crcAbsorb_d;
  logic [DATA_WIDTH-1:0]   crcRestart_d;
  logic [DATA_WIDTH-1:0]   crcShift_d;
  logic                    bitMismatch_d;
  logic                    frameErr_d;
  logic                    lastCrcBit_d;
  logic [IDX_W-1:0]        idxInc_d;
  logic [15:0]             bitCntInc_d;
  logic [7:0]              errCntInc_d;

  // One CRC step: absorb payload bit d into register r.
  function automatic logic [DATA_WIDTH-1:0] absorb(
    input logic [DATA_WIDTH-1:0] r,
    input logic                  d
  );
    absorb = (r >> 1) ^ ((d ^ r[0]) ? FB_MASK : '0);
  endfunction

  // Candidate next values shared by several FSM branches. crcRestart_d is
  // used when a new frame starts: the register is seeded and the first
  // payload bit absorbed on the same edge.
  always_comb begin
    crcAbsorb_d   = absorb(crc_q, DATA);
    crcRestart_d  = absorb(SEED, DATA);
    crcShift_d    = crc_q >> 1;
    bitMismatch_d = CRC_IN ^ crc_q[0];
    frameErr_d    = sticky_q | bitMismatch_d;
    lastCrcBit_d  = (idx_q == IDX_W'(DATA_WIDTH - 1));
    idxInc_d      = idx_q + IDX_W'(1);
    bitCntInc_d   = (bitCnt_q == 16'hFFFF) ? bitCnt_q : bitCnt_q + 16'd1;
    errCntInc_d   = (errCnt_q == 8'hFF) ? errCnt_q : errCnt_q + 8'd1;
  end

  // Frame FSM with registered outputs. idx_q and sticky_q are always zero
  // while in RX_DATA (cleared on every exit from RX_CRC), so the first CRC
  // bit seen in RX_DATA can share the RX_CRC bit handling.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      crc_q    <= SEED;
      bitCnt_q <= 16'd0;
      idx_q    <= '0;
      sticky_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      len_q    <= 16'd0;
      errCnt_q <= 8'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ACTIVE) begin
            crc_q    <= crcRestart_d;
            bitCnt_q <= 16'd1;
            state_q  <= RX_DATA;
          end
        end

        RX_DATA, RX_CRC: begin
          if (ACTIVE) begin
            if (state_q == RX_DATA) begin
              crc_q    <= crcAbsorb_d;
              bitCnt_q <= bitCntInc_d;
            end else begin
              // Payload during the CRC field aborts the frame and the
              // same bit becomes bit 1 of the next frame.
              done_q   <= 1'b1;
              err_q    <= 1'b1;
              len_q    <= bitCnt_q;
              errCnt_q <= errCntInc_d;
              crc_q    <= crcRestart_d;
              bitCnt_q <= 16'd1;
              sticky_q <= 1'b0;
              idx_q    <= '0;
              state_q  <= RX_DATA;
            end
          end else if (CRC_VALID) begin
            if (lastCrcBit_d) begin
              done_q   <= 1'b1;
              err_q    <= frameErr_d;
              len_q    <= bitCnt_q;
              if (frameErr_d) begin
                errCnt_q <= errCntInc_d;
              end
              crc_q    <= SEED;
              bitCnt_q <= 16'd0;
              sticky_q <= 1'b0;
              idx_q    <= '0;
              state_q  <= IDLE;
            end else begin
              crc_q    <= crcShift_d;
              sticky_q <= frameErr_d;
              idx_q    <= idxInc_d;
              state_q  <= RX_CRC;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign DONE    = done_q;
  assign ERR     = err_q;
  assign LEN     = len_q;
  assign ERR_CNT = errCnt_q;

endmodule

// File: tb/tb_crc_checker.sv
// ---------------------------------------------------------------------------
// tb_crc_checker
//
// Self-checking bench for crc_checker (8-bit CRC, seed 8'hD8). A frame-level
// reference model collects each frame's payload and received CRC byte and
// decides the result once the frame ends; a compare process checks DONE,
// ERR, LEN and ERR_CNT against it every falling clock edge. Directed
// scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_crc_checker;

  logic        CLK = 1'b0;
  logic        RST;
  logic        DATA;
  logic        ACTIVE;
  logic        CRC_IN;
  logic        CRC_VALID;
  logic        DONE;
  logic        ERR;
  logic [15:0] LEN;
  logic [7:0]  ERR_CNT;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state.
  int         mPhase  = 0;   // 0 idle, 1 payload, 2 crc field
  int         mLen    = 0;
  int         rxCnt   = 0;
  logic [7:0] rxCrc   = 8'h00;
  bit         pay[$];
  logic       eDone   = 1'b0;
  logic       eErr    = 1'b0;
  int         eLen    = 0;
  int         eErrCnt = 0;

  crc_checker #(
    .DATA_WIDTH(8),
    .SEED      (8'hD8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .DATA     (DATA),
    .ACTIVE   (ACTIVE),
    .CRC_IN   (CRC_IN),
    .CRC_VALID(CRC_VALID),
    .DONE     (DONE),
    .ERR      (ERR),
    .LEN      (LEN),
    .ERR_CNT  (ERR_CNT)
  );

  always #5 CLK = ~CLK;

  // CRC of a whole payload, written directly from the per-bit register
  // equations.
  function automatic logic [7:0] crcOf(input bit q[$]);
    logic [7:0] r;
    logic [7:0] n;
    logic       fb;
    r = 8'hD8;
    foreach (q[i]) begin
      fb   = q[i] ^ r[0];
      n[7] = fb;
      n[6] = fb ^ r[7];
      n[5] = r[6];
      n[4] = r[5];
      n[3] = r[4];
      n[2] = fb ^ r[3];
      n[1] = r[2];
      n[0] = r[1];
      r    = n;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nChecks++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: result of a frame as seen from the outside.
  task automatic modelReport(input logic err);
    eDone = 1'b1;
    eErr  = err;
    eLen  = mLen;
    if (err && eErrCnt < 255) eErrCnt++;
  endtask

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mPhase  = 0;
      mLen    = 0;
      rxCnt   = 0;
      rxCrc   = 8'h00;
      pay.delete();
      eDone   = 1'b0;
      eErr    = 1'b0;
      eLen    = 0;
      eErrCnt = 0;
    end else begin
      eDone = 1'b0;
      if (ACTIVE) begin
        if (mPhase == 2) modelReport(1'b1);
        if (mPhase != 1) begin
          pay.delete();
          mLen  = 0;
          rxCnt = 0;
        end
        pay.push_back(DATA);
        if (mLen < 65535) mLen++;
        mPhase = 1;
      end else if (CRC_VALID && mPhase != 0) begin
        rxCrc[rxCnt] = CRC_IN;
        rxCnt++;
        mPhase = 2;
        if (rxCnt == 8) begin
          modelReport(rxCrc != crcOf(pay));
          mPhase = 0;
          rxCnt  = 0;
        end
      end
    end
  end

  // Compare process: outputs against the model on every falling edge.
  always @(negedge CLK) begin
    checkOutput("DONE", 32'(DONE), 32'(eDone));
    checkOutput("ERR", 32'(ERR), 32'(eErr));
    checkOutput("LEN", 32'(LEN), eLen);
    checkOutput("ERR_CNT", 32'(ERR_CNT), eErrCnt);
  end

  // Drive one cycle of inputs; returns 1 ns after the edge that sampled them.
  task automatic applyStimulus(input logic a, input logic d, input logic v,
                               input logic c);
    ACTIVE    = a;
    DATA      = d;
    CRC_VALID = v;
    CRC_IN    = c;
    @(posedge CLK);
    #1;
  endtask

  // Payload bits p[0..n-1], then the CRC byte LSB first with 'gap' idle
  // cycles before each CRC bit. Payload bit 'prio' also raises CRC_VALID.
  task automatic sendFrame(input logic [31:0] p, input int n,
                           input logic [7:0] crc, input int gap,
                           input int prio);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, p[i], (i == prio), 1'b1);
    for (int j = 0; j < 8; j++) begin
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, crc[j]);
    end
  endtask

  task automatic checkResult(input string tag, input logic err,
                             input int len, input int cnt);
    checkOutput({tag, "_done"}, 32'(DONE), 32'd1);
    checkOutput({tag, "_err"}, 32'(ERR), 32'(err));
    checkOutput({tag, "_len"}, 32'(LEN), len);
    checkOutput({tag, "_errcnt"}, 32'(ERR_CNT), cnt);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit         q[$];
    logic [7:0] c;

    RST = 1'b0;
    ACTIVE = 1'b0; DATA = 1'b0; CRC_VALID = 1'b0; CRC_IN = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_done", 32'(DONE), 32'd0);
    checkOutput("rst_err", 32'(ERR), 32'd0);
    checkOutput("rst_len", 32'(LEN), 32'd0);
    checkOutput("rst_errcnt", 32'(ERR_CNT), 32'd0);
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Pin the model against hand-computed CRCs.
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(1'b0);
    checkOutput("model_crc_zeros", 32'(crcOf(q)), 32'h14);
    q.delete();
    q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1); q.push_back(1'b1);
    checkOutput("model_crc_1011", 32'(crcOf(q)), 32'hB3);

    // Good frame.
    sendFrame(32'h0, 8, 8'h14, 0, -1);
    checkResult("good", 1'b0, 8, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("good_pulse_end", 32'(DONE), 32'd0);
    checkOutput("good_err_held", 32'(ERR), 32'd0);

    // Bad frame.
    sendFrame(32'h0, 8, 8'h15, 0, -1);
    checkResult("bad", 1'b1, 8, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("bad_err_held", 32'(ERR), 32'd1);

    // CRC gaps plus ACTIVE/CRC_VALID overlap in the payload.
    sendFrame(32'h0, 8, 8'h14, 3, 4);
    checkResult("gap_prio", 1'b0, 8, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Non-zero payload 1,0,1,1 with CRC 0xB3.
    sendFrame(32'hD, 4, 8'hB3, 0, -1);
    checkResult("p1011", 1'b0, 4, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Longer payload, CRC taken from the model.
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(bit'((32'hA5C3_1E77 >> i) & 1));
    c = crcOf(q);
    sendFrame(32'hA5C3_1E77, 20, c, 1, -1);
    checkResult("long", 1'b0, 20, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Abort after 3 CRC bits, then the aborting bit starts a new frame.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkResult("abort", 1'b1, 8, 2);
    sendFrame(32'h0, 7, 8'h14, 0, -1);
    checkResult("after_abort", 1'b0, 8, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of the CRC field.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) applyStimulus(1'b0, 1'b0, 1'b1, ((8'h14 >> j) & 1) != 0);
    RST = 1'b0;
    #1;
    checkOutput("midrst_errcnt", 32'(ERR_CNT), 32'd0);
    checkOutput("midrst_len", 32'(LEN), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    sendFrame(32'h0, 8, 8'h14, 0, -1);
    checkResult("post_rst", 1'b0, 8, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // 256 bad frames saturate the error counter.
    for (int f = 0; f < 256; f++) sendFrame(32'h0, 8, 8'h15, 0, -1);
    checkResult("sat", 1'b1, 8, 255);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_held", 32'(ERR_CNT), 32'd255);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/crc_checker.md
CRC_CHECKER -- requirements
Module: crc_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the CRC register and the CRC field in bits.
REQ-002 Parameter SEED, default 8'hD8: CRC register value at reset and at the start of every frame.
REQ-003 CLK  input  1  clock; all state changes on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 DATA  input  1  serial payload bit, sampled while ACTIVE=1.
REQ-006 ACTIVE  input  1  payload qualifier; high for each payload bit cycle.
REQ-007 CRC_IN  input  1  serial received CRC bit, LSB first, sampled while CRC_VALID=1.
REQ-008 CRC_VALID  input  1  CRC bit qualifier.
REQ-009 DONE  output  1  one-cycle pulse; frame result is valid.
REQ-010 ERR  output  1  result of the last completed frame (1 = CRC mismatch or aborted); held until the next DONE.
REQ-011 LEN  output  16  payload bit count of the last completed frame; held until the next DONE.
REQ-012 ERR_CNT  output  8  count of frames reported with ERR=1.

Function
REQ-013 The CRC register r SHALL update on each absorbed bit: fb=DATA^r[0]; r[7]<=fb; r[6]<=fb^r[7]; r[5]<=r[6]; r[4]<=r[5]; r[3]<=r[4]; r[2]<=fb^r[3]; r[1]<=r[2]; r[0]<=r[1].
REQ-014 The FSM SHALL have three states: IDLE, RX_DATA and RX_CRC.
REQ-015 IDLE: r=SEED. ACTIVE=1 absorbs DATA, sets the bit count to 1 and goes to RX_DATA. CRC_VALID is ignored.
REQ-016 RX_DATA: ACTIVE=1 absorbs DATA and increments the bit count, saturating at 65535.
REQ-017 RX_DATA: ACTIVE=0 with CRC_VALID=1 compares CRC_IN against r[0], shifts r right (zero fill), sets the CRC index to 1 and goes to RX_CRC. ACTIVE=0 with CRC_VALID=0 holds all state.
REQ-018 RX_CRC: each CRC_VALID=1 cycle compares CRC_IN against r[0], shifts r right and increments the index. Cycles with CRC_VALID=0 hold all state; gaps of any length are allowed.
REQ-019 Any CRC bit mismatch SHALL set a sticky mismatch flag for the frame.
REQ-020 On the edge that samples the DATA_WIDTH-th CRC bit, the block SHALL set DONE=1, ERR=(sticky flag OR current-bit mismatch) and LEN=bit count, reload r with SEED, clear the flag and go to IDLE.
REQ-021 DONE SHALL be high for exactly the one cycle after the last CRC bit, i.e. a latency of 1 clock.
REQ-022 ACTIVE=1 in RX_CRC SHALL abort the frame: on the same edge, DONE=1, ERR=1 and LEN=bit count. r reloads with SEED and DATA is absorbed as bit 1 of a new frame in RX_DATA.
REQ-023 When ACTIVE=1 and CRC_VALID=1 occur together, ACTIVE SHALL take priority and CRC_VALID SHALL be ignored.
REQ-024 ERR_CNT SHALL increment on every DONE with ERR=1 and saturate at 255.
REQ-025 DONE SHALL be 0 in every cycle without a completion or an abort.

Reset
REQ-026 RST=0 SHALL immediately force state=IDLE, r=SEED, DONE=0, ERR=0, LEN=0, ERR_CNT=0, sticky flag=0, and bit and index counters=0, including in the middle of a frame.
REQ-027 After RST rises, the first ACTIVE=1 edge SHALL start a fresh frame; the partial frame in progress at reset is never reported.

Verification
REQ-028 Reset check: assert RST=0 -> DONE=0, ERR=0, LEN=0, ERR_CNT=0.
REQ-029 Good frame: 8 DATA=0 bits, then CRC 0x14 LSB first (0,0,1,0,1,0,0,0) -> one cycle after the last CRC bit: DONE=1 for 1 cycle, ERR=0, LEN=8, ERR_CNT=0.
REQ-030 Bad frame: same payload, CRC 0x15 -> DONE=1, ERR=1, LEN=8, ERR_CNT=1.
REQ-031 Gaps and priority: good frame with 3-cycle CRC_VALID gaps and one cycle of ACTIVE=1 with CRC_VALID=1 inside the payload -> result identical to REQ-029, with LEN counting that bit.
REQ-032 Abort: ACTIVE=1 (DATA=0) after 3 CRC bits -> DONE=1, ERR=1 next cycle; then 7 more DATA=0 bits and CRC 0x14 -> DONE=1, ERR=0, LEN=8.
REQ-033 Reset mid-CRC: pulse RST after 4 CRC bits, then run the good frame -> no DONE before it, then ERR=0 and ERR_CNT=0; 256 bad frames -> ERR_CNT=255.
